// File: rtl/ay_bus_if.sv
// CPU-side bus of the AY PSG front end (BC2 tied high externally).
// Bus semantics: {bdir,bc1} is sampled on every rising clk edge with no
// handshake or back-pressure. 00 = inactive, 01 = read, 10 = write,
// 11 = latch address. Read data appears with data_oe=1 exactly one cycle
// after each selected read cycle; data_out is 0 whenever data_oe is 0.
interface ay_bus_if;
  logic       bdir;
  logic       bc1;
  logic [7:0] data_in;
  logic [7:0] data_out;
  logic       data_oe;

  modport master (
    output bdir,
    output bc1,
    output data_in,
    input  data_out,
    input  data_oe
  );

  modport slave (
    input  bdir,
    input  bc1,
    input  data_in,
    output data_out,
    output data_oe
  );
endinterface

// File: rtl/ay_bus_regs.sv
// AY-3-891x register front end: decodes the BDIR/BC1 bus into a 16-entry
// register file, presents the decoded fields to the sound stages and
// generates the tone/noise and envelope count-enable strobes.
module ay_bus_regs #(
  parameter logic [3:0] ADDR_HI = 4'b0000,
  parameter int         CLK_DIV = 8
) (
  input  logic        clk,
  input  logic        reset,
  ay_bus_if.slave     bus,
  output logic [11:0] tone_period_a,
  output logic [11:0] tone_period_b,
  output logic [11:0] tone_period_c,
  output logic [4:0]  noise_period,
  output logic [7:0]  mixer,
  output logic [4:0]  amp_a,
  output logic [4:0]  amp_b,
  output logic [4:0]  amp_c,
  output logic [15:0] env_period,
  output logic [3:0]  env_shape,
  output logic        env_restart,
  output logic [7:0]  io_a,
  output logic [7:0]  io_b,
  output logic        tick_tone,
  output logic        tick_env
);

  typedef enum logic [1:0] {
    MODE_IDLE  = 2'b00,
    MODE_READ  = 2'b01,
    MODE_WRITE = 2'b10,
    MODE_LATCH = 2'b11
  } bus_mode_t;

  localparam int CW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(CLK_DIV - 1);

  bus_mode_t   mode;
  bus_mode_t   mode_q;
  logic [7:0]  regs [16];
  logic [3:0]  addr;
  logic        sel;
  logic        commit;
  logic [CW-1:0] cnt;
  logic        env_phase;
  logic        wrap;

  // Unused bits are never stored, so read-back returns them as zero.
  function automatic logic [7:0] store_mask(input logic [3:0] a);
    case (a)
      4'd1, 4'd3, 4'd5, 4'd13: store_mask = 8'h0F;
      4'd6, 4'd8, 4'd9, 4'd10: store_mask = 8'h1F;
      default:                 store_mask = 8'hFF;
    endcase
  endfunction

  assign mode   = bus_mode_t'({bus.bdir, bus.bc1});
  // Only the first cycle of a write run commits; later cycles are ignored.
  assign commit = (mode == MODE_WRITE) && (mode_q != MODE_WRITE) && sel;
  assign wrap   = (cnt == CNT_MAX);

  // Bus decode: address latch, chip select, write commit and read-back.
  always_ff @(posedge clk) begin
    if (reset) begin
      mode_q       <= MODE_IDLE;
      addr         <= 4'd0;
      sel          <= 1'b0;
      env_restart  <= 1'b0;
      bus.data_oe  <= 1'b0;
      bus.data_out <= 8'd0;
      for (int i = 0; i < 16; i++) regs[i] <= 8'd0;
    end else begin
      mode_q      <= mode;
      env_restart <= commit && (addr == 4'd13);
      if (mode == MODE_LATCH) begin
        if (bus.data_in[7:4] == ADDR_HI) begin
          addr <= bus.data_in[3:0];
          sel  <= 1'b1;
        end else begin
          sel  <= 1'b0;
        end
      end
      if (commit) regs[addr] <= bus.data_in & store_mask(addr);
      if ((mode == MODE_READ) && sel) begin
        bus.data_oe  <= 1'b1;
        bus.data_out <= regs[addr];
      end else begin
        bus.data_oe  <= 1'b0;
        bus.data_out <= 8'd0;
      end
    end
  end

  // Free-running prescaler; strobes are registered so they land on the
  // cycle after the counter wraps (first tone tick at n=CLK_DIV).
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt       <= '0;
      env_phase <= 1'b0;
      tick_tone <= 1'b0;
      tick_env  <= 1'b0;
    end else begin
      cnt       <= wrap ? '0 : cnt + 1'b1;
      tick_tone <= wrap;
      tick_env  <= wrap && env_phase;
      if (wrap) env_phase <= ~env_phase;
    end
  end

  assign tone_period_a = {regs[1][3:0], regs[0]};
  assign tone_period_b = {regs[3][3:0], regs[2]};
  assign tone_period_c = {regs[5][3:0], regs[4]};
  assign noise_period  = regs[6][4:0];
  assign mixer         = regs[7];
  assign amp_a         = regs[8][4:0];
  assign amp_b         = regs[9][4:0];
  assign amp_c         = regs[10][4:0];
  assign env_period    = {regs[12], regs[11]};
  assign env_shape     = regs[13][3:0];
  assign io_a          = regs[14];
  assign io_b          = regs[15];

endmodule
